// File: rtl/fixed_math_pkg.sv
// Shared fixed-point arithmetic types and saturation constants.
// Saturation helpers return 64-bit words; only the low n bits are meaningful.
package fixed_math_pkg;

   typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_DONE} div_state_t;

   function automatic logic [63:0] fx_max(input int unsigned n);
      return (64'd1 << (n - 1)) - 64'd1;
   endfunction

   function automatic logic [63:0] fx_min(input int unsigned n);
      return ~64'd0 << (n - 1);
   endfunction

endpackage

// File: rtl/fixed_saturate.sv
// Unsigned magnitude plus sign to signed OUT_W result, clipped to MAX/MIN.
// Expects IN_W > OUT_W; negative magnitudes up to 2^(OUT_W-1) are representable.
module fixed_saturate
   import fixed_math_pkg::*;
#(
   parameter int unsigned IN_W  = 44,
   parameter int unsigned OUT_W = 32
) (
   input  logic [IN_W-1:0]  mag,
   input  logic             neg,
   output logic [OUT_W-1:0] result,
   output logic             sat
);

   localparam logic [63:0] MaxWide = fx_max(OUT_W);
   localparam logic [63:0] MinWide = fx_min(OUT_W);
   localparam logic [OUT_W-1:0] MaxVal = MaxWide[OUT_W-1:0];
   localparam logic [OUT_W-1:0] MinVal = MinWide[OUT_W-1:0];

   logic over_hi;
   logic low_rest;

   assign over_hi  = |mag[IN_W-1:OUT_W];
   assign low_rest = |mag[OUT_W-2:0];

   always_comb begin
      result = '0;
      sat    = 1'b0;
      if (neg) begin
         // Exactly 2^(OUT_W-1) negates to MIN without clipping.
         if (over_hi || (mag[OUT_W-1] && low_rest)) begin
            result = MinVal;
            sat    = 1'b1;
         end else begin
            result = ~mag[OUT_W-1:0] + 1'b1;
         end
      end else begin
         if (over_hi || mag[OUT_W-1]) begin
            result = MaxVal;
            sat    = 1'b1;
         end else begin
            result = mag[OUT_W-1:0];
         end
      end
   end

endmodule

// File: rtl/fixed_divide_seq.sv
// Sequential signed fixed-point divider, q = (a << F) / b, restoring shift-subtract.
// One quotient bit per cycle; fixed latency regardless of operands.
module fixed_divide_seq
   import fixed_math_pkg::*;
#(
   parameter int unsigned FRACTIONAL_SIZE = 12,
   parameter int unsigned OPERAND_SIZE    = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [OPERAND_SIZE-1:0] a,
   input  logic [OPERAND_SIZE-1:0] b,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [OPERAND_SIZE-1:0] q,
   output logic                    saturated,
   output logic                    div_by_zero
);

   localparam int unsigned N    = OPERAND_SIZE;
   localparam int unsigned F    = FRACTIONAL_SIZE;
   localparam int unsigned W    = N + F;
   localparam int unsigned CntW = $clog2(W);

   localparam logic [63:0] MaxWide = fx_max(N);
   localparam logic [63:0] MinWide = fx_min(N);
   localparam logic [N-1:0] MaxVal = MaxWide[N-1:0];
   localparam logic [N-1:0] MinVal = MinWide[N-1:0];

   div_state_t      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            fin_q, fin_d;
   logic            sign_q, sign_d;
   logic            a_neg_q, a_neg_d;
   logic            b_zero_q, b_zero_d;
   logic [N-1:0]    b_abs_q, b_abs_d;
   logic [N:0]      rem_q, rem_d;
   logic [W-1:0]    quot_q, quot_d;
   logic [N-1:0]    q_q, q_d;
   logic            sat_q, sat_d;
   logic            dbz_q, dbz_d;

   logic [N-1:0]    a_abs;
   logic [N-1:0]    b_abs;
   logic [N+1:0]    rem_shift;
   logic            rem_ge;
   logic [N-1:0]    sat_val;
   logic            sat_flag;

   assign a_abs     = a[N-1] ? (~a + 1'b1) : a;
   assign b_abs     = b[N-1] ? (~b + 1'b1) : b;
   assign rem_shift = {rem_q, quot_q[W-1]};
   assign rem_ge    = rem_shift >= (N+2)'(b_abs_q);

   fixed_saturate #(
      .IN_W  (W),
      .OUT_W (N)
   ) u_sat (
      .mag    (quot_q),
      .neg    (sign_q),
      .result (sat_val),
      .sat    (sat_flag)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      fin_d    = fin_q;
      sign_d   = sign_q;
      a_neg_d  = a_neg_q;
      b_zero_d = b_zero_q;
      b_abs_d  = b_abs_q;
      rem_d    = rem_q;
      quot_d   = quot_q;
      q_d      = q_q;
      sat_d    = sat_q;
      dbz_d    = dbz_q;
      unique case (state_q)
         DIV_IDLE: begin
            if (in_valid) begin
               sign_d   = a[N-1] ^ b[N-1];
               a_neg_d  = a[N-1];
               b_zero_d = (b == '0);
               b_abs_d  = b_abs;
               rem_d    = '0;
               quot_d   = {a_abs, {F{1'b0}}};
               cnt_d    = CntW'(W - 1);
               fin_d    = 1'b0;
               state_d  = DIV_CALC;
            end
         end
         DIV_CALC: begin
            if (!fin_q) begin
               // Dividend bits shift out of quot_q while quotient bits shift in.
               rem_d  = rem_ge ? (N+1)'(rem_shift - (N+2)'(b_abs_q)) : (N+1)'(rem_shift);
               quot_d = {quot_q[W-2:0], rem_ge};
               if (cnt_q == '0) begin
                  fin_d = 1'b1;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end else begin
               fin_d   = 1'b0;
               state_d = DIV_DONE;
               if (b_zero_q) begin
                  q_d   = a_neg_q ? MinVal : MaxVal;
                  sat_d = 1'b1;
                  dbz_d = 1'b1;
               end else begin
                  q_d   = sat_val;
                  sat_d = sat_flag;
                  dbz_d = 1'b0;
               end
            end
         end
         DIV_DONE: begin
            if (out_ready) begin
               state_d = DIV_IDLE;
            end
         end
         default: state_d = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= DIV_IDLE;
         cnt_q    <= '0;
         fin_q    <= 1'b0;
         sign_q   <= 1'b0;
         a_neg_q  <= 1'b0;
         b_zero_q <= 1'b0;
         b_abs_q  <= '0;
         rem_q    <= '0;
         quot_q   <= '0;
         q_q      <= '0;
         sat_q    <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         fin_q    <= fin_d;
         sign_q   <= sign_d;
         a_neg_q  <= a_neg_d;
         b_zero_q <= b_zero_d;
         b_abs_q  <= b_abs_d;
         rem_q    <= rem_d;
         quot_q   <= quot_d;
         q_q      <= q_d;
         sat_q    <= sat_d;
         dbz_q    <= dbz_d;
      end
   end

   assign in_ready    = (state_q == DIV_IDLE);
   assign out_valid   = (state_q == DIV_DONE);
   assign q           = q_q;
   assign saturated   = out_valid & sat_q;
   assign div_by_zero = out_valid & dbz_q;

endmodule

// File: tb/tb_fixed_divide_seq.sv
// Scoreboard bench for fixed_divide_seq: driver pushes model results, monitor pops on handshake.
module tb_fixed_divide_seq;

   localparam int N   = 32;
   localparam int F   = 12;
   localparam int Lat = N + F + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b1;
   logic [N-1:0]  a = '0;
   logic [N-1:0]  b = '0;
   logic          in_ready;
   logic          out_valid;
   logic [N-1:0]  q;
   logic          saturated;
   logic          div_by_zero;

   fixed_divide_seq #(
      .FRACTIONAL_SIZE (F),
      .OPERAND_SIZE    (N)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .q           (q),
      .saturated   (saturated),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [N-1:0] q;
      logic         sat;
      logic         dbz;
      int           acc;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Plain arithmetic: exact integer division truncates toward zero, then clip.
   function automatic exp_t model(input logic [N-1:0] aa, input logic [N-1:0] bb);
      exp_t   e;
      longint sa, sbv, r;
      sa = longint'($signed(aa));
      sbv = longint'($signed(bb));
      e.sat = 1'b0;
      e.dbz = 1'b0;
      e.acc = 0;
      e.q = '0;
      if (sbv == 0) begin
         e.dbz = 1'b1;
         e.sat = 1'b1;
         e.q = (sa < 0) ? 32'h8000_0000 : 32'h7fff_ffff;
      end else begin
         r = (sa * (64'sd1 <<< F)) / sbv;
         if (r > 64'sd2147483647) begin
            e.q = 32'h7fff_ffff;
            e.sat = 1'b1;
         end else if (r < -64'sd2147483648) begin
            e.q = 32'h8000_0000;
            e.sat = 1'b1;
         end else begin
            e.q = r[N-1:0];
         end
      end
      return e;
   endfunction

   task automatic issue(input logic [N-1:0] aa, input logic [N-1:0] bb);
      exp_t e;
      int   waited = 0;
      @(negedge clk);
      while (!in_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         fail_now("issue_timeout");
         return;
      end
      a = aa;
      b = bb;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      e = model(aa, bb);
      e.acc = cyc;
      exp_q.push_back(e);
      in_valid = 1'b0;
      a = $urandom;
      b = $urandom;
   endtask

   task automatic drain();
      int w = 0;
      while (exp_q.size() != 0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (exp_q.size() != 0) fail_now("drain_timeout");
   endtask

   logic ov_prev = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         ov_prev <= 1'b0;
      end else begin
         if (out_valid && !ov_prev) begin
            if (exp_q.size() == 0) fail_now("unexpected_out_valid");
            else check("latency", 64'(cyc - exp_q[0].acc), 64'(Lat));
         end
         if (out_valid && out_ready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("q", q, e.q);
            check("saturated", saturated, e.sat);
            check("div_by_zero", div_by_zero, e.dbz);
         end
         ov_prev <= out_valid;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   logic [N-1:0] dir_a [10] = '{32'd24576, 32'hffff_f000, 32'hffff_f000, 32'd4096, 32'hffff_ffff,
                                32'h4000_0000, 32'h8000_0000, 32'd0, 32'd0, 32'h8000_0000};
   logic [N-1:0] dir_b [10] = '{32'd8192, 32'd12288, 32'hffff_e000, 32'd0, 32'd0,
                                32'd1, 32'd4096, 32'd0, 32'd4096, 32'hffff_ffff};

   initial begin
      logic [N-1:0] ra, rb;
      int           w;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_q", q, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_saturated", saturated, 0);
      check("rst_div_by_zero", div_by_zero, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) issue(dir_a[i], dir_b[i]);
      drain();

      // Backpressure: result held in DONE, input pulses ignored
      out_ready = 1'b0;
      issue(32'd8192, 32'd4096);
      w = 0;
      while (!out_valid && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (!out_valid) fail_now("bp_wait_timeout");
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         in_valid = ~in_valid;
         a = 32'd4096;
         b = 32'd4096;
         @(negedge clk);
         check("bp_q", q, 32'd8192);
         check("bp_out_valid", out_valid, 1);
         check("bp_in_ready", in_ready, 0);
         check("bp_saturated", saturated, 0);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_release_in_ready", in_ready, 1);
      check("bp_release_out_valid", out_valid, 0);
      check("bp_queue_empty", 64'(exp_q.size()), 0);

      // Reset mid-calculation discards the op
      issue(32'd24576, 32'd8192);
      repeat (20) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_q", q, 0);
      check("midrst_in_ready", in_ready, 1);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      issue(32'd8192, 32'd4096);
      drain();

      // Random operands against the model
      for (int i = 0; i < 1200; i++) begin
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 3))
            0: ;
            1: rb = {{15{rb[16]}}, rb[16:0]};
            2: rb = 32'($urandom_range(0, 2)) - 32'd1;
            default: ra = {{12{ra[19]}}, ra[19:0]};
         endcase
         issue(ra, rb);
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
